// File: rtl/misaligned_load_unit_if.sv
// Bundles the request, memory and response channels of the load unit.
// No logic, so no latency of its own.
// Backpressure travels on the valid/ready pairs of each channel.
interface misaligned_load_unit_if #(
   parameter int XLEN = 32
);
   // Request channel
   logic            i_req_valid;
   logic            o_req_ready;
   logic [XLEN-1:0] i_addr;
   logic [2:0]      i_funct3;
   // Memory read channel
   logic            o_mem_req_valid;
   logic            i_mem_req_ready;
   logic [XLEN-1:0] o_mem_addr;
   logic            i_mem_rsp_valid;
   logic [XLEN-1:0] i_mem_rdata;
   // Response channel
   logic            o_rsp_valid;
   logic            i_rsp_ready;
   logic [XLEN-1:0] o_rsp_data;
   logic            o_rsp_err;

   // Load unit side
   modport slave (
      input  i_req_valid, i_addr, i_funct3,
      input  i_mem_req_ready, i_mem_rsp_valid, i_mem_rdata,
      input  i_rsp_ready,
      output o_req_ready, o_mem_req_valid, o_mem_addr,
      output o_rsp_valid, o_rsp_data, o_rsp_err
   );

   // Requester and memory side
   modport master (
      output i_req_valid, i_addr, i_funct3,
      output i_mem_req_ready, i_mem_rsp_valid, i_mem_rdata,
      output i_rsp_ready,
      input  o_req_ready, o_mem_req_valid, o_mem_addr,
      input  o_rsp_valid, o_rsp_data, o_rsp_err
   );
endinterface

// File: rtl/misaligned_load_unit.sv
// Load unit: splits word-crossing loads into two aligned reads, then extracts and extends.
// Latency: 3 cycles aligned, 5 cycles crossing, 1 cycle on error (zero-wait memory).
// Backpressure: memory request held until accepted; response held until consumer ready.
module misaligned_load_unit #(
   parameter int XLEN               = 32,
   parameter int SUPPORT_MISALIGNED = 1
) (
   input logic                   i_clk,
   input logic                   i_rst_n,
   misaligned_load_unit_if.slave bus
);

   localparam int B    = XLEN / 8;
   localparam int OFFW = $clog2(B);

   typedef enum logic [2:0] {
      IDLE,
      REQ1,
      WAIT1,
      REQ2,
      WAIT2,
      RESP
   } state_t;

   state_t          state;
   state_t          state_nxt;

   logic [XLEN-1:0] addr_q;
   logic [2:0]      funct3_q;
   logic            err_q;
   logic [XLEN-1:0] lo_q;
   logic [XLEN-1:0] hi_q;

   logic            req_fire;
   logic            req_err;
   logic [OFFW-1:0] req_off;
   logic [OFFW-1:0] q_off;
   logic            q_cross;
   logic [XLEN-1:0] aligned_addr;

   logic            req_ready;
   logic            mem_req_valid;
   logic [XLEN-1:0] mem_addr;
   logic            rsp_valid;
   logic [XLEN-1:0] rsp_data;

   logic [OFFW+2:0] shamt;
   logic [XLEN-1:0] window;
   logic [XLEN-1:0] result;
   logic            sign_bit;
   int              nbits;

   // funct3 values this width can execute; LD and LWU exist only on 64-bit
   function automatic logic legal_f3(input logic [2:0] f3);
      case (f3)
         3'b000, 3'b001, 3'b010, 3'b100, 3'b101: return 1'b1;
         3'b011, 3'b110:                         return (XLEN == 64);
         default:                                return 1'b0;
      endcase
   endfunction

   // Access size in bytes comes straight from the low two funct3 bits
   function automatic logic [3:0] size_of(input logic [2:0] f3);
      return 4'd1 << f3[1:0];
   endfunction

   // True when the access spills past the end of its aligned word
   function automatic logic crosses(input logic [OFFW-1:0] off, input logic [2:0] f3);
      logic [4:0] span;
      span = 5'(off) + 5'(size_of(f3));
      return span > 5'(B);
   endfunction

   assign req_off      = bus.i_addr[OFFW-1:0];
   assign req_fire     = bus.i_req_valid && req_ready;
   assign req_err      = !legal_f3(bus.i_funct3) ||
                         ((SUPPORT_MISALIGNED == 0) && crosses(req_off, bus.i_funct3));
   assign q_off        = addr_q[OFFW-1:0];
   assign q_cross      = crosses(q_off, funct3_q);
   assign aligned_addr = {addr_q[XLEN-1:OFFW], {OFFW{1'b0}}};

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Request capture and read-data capture; held steady for the whole operation
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         addr_q   <= '0;
         funct3_q <= '0;
         err_q    <= 1'b0;
         lo_q     <= '0;
         hi_q     <= '0;
      end else begin
         if (req_fire) begin
            addr_q   <= bus.i_addr;
            funct3_q <= bus.i_funct3;
            err_q    <= req_err;
         end
         if ((state == WAIT1) && bus.i_mem_rsp_valid) begin
            lo_q <= bus.i_mem_rdata;
         end
         if ((state == WAIT2) && bus.i_mem_rsp_valid) begin
            hi_q <= bus.i_mem_rdata;
         end
      end
   end

   // Next-state and handshake outputs; all outputs depend on state only
   always_comb begin
      state_nxt     = state;
      req_ready     = 1'b0;
      mem_req_valid = 1'b0;
      mem_addr      = '0;
      rsp_valid     = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (bus.i_req_valid) begin
               state_nxt = req_err ? RESP : REQ1;
            end
         end
         REQ1: begin
            mem_req_valid = 1'b1;
            mem_addr      = aligned_addr;
            if (bus.i_mem_req_ready) begin
               state_nxt = WAIT1;
            end
         end
         WAIT1: begin
            if (bus.i_mem_rsp_valid) begin
               state_nxt = q_cross ? REQ2 : RESP;
            end
         end
         REQ2: begin
            mem_req_valid = 1'b1;
            mem_addr      = aligned_addr + XLEN'(B);
            if (bus.i_mem_req_ready) begin
               state_nxt = WAIT2;
            end
         end
         WAIT2: begin
            if (bus.i_mem_rsp_valid) begin
               state_nxt = RESP;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (bus.i_rsp_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Byte extraction from the {hi,lo} pair, then sign or zero extension
   always_comb begin
      shamt  = {q_off, 3'b000};
      window = XLEN'({hi_q, lo_q} >> shamt);
      case (funct3_q[1:0])
         2'b00:   begin nbits = 8;  sign_bit = window[7];      end
         2'b01:   begin nbits = 16; sign_bit = window[15];     end
         2'b10:   begin nbits = 32; sign_bit = window[31];     end
         default: begin nbits = 64; sign_bit = window[XLEN-1]; end
      endcase
      sign_bit = sign_bit && !funct3_q[2];
      result   = '0;
      for (int i = 0; i < XLEN; i++) begin
         result[i] = (i < nbits) ? window[i] : sign_bit;
      end
   end

   // Response data is zero outside RESP and on any fault
   assign rsp_data = ((state == RESP) && !err_q) ? result : '0;

   assign bus.o_req_ready     = req_ready;
   assign bus.o_mem_req_valid = mem_req_valid;
   assign bus.o_mem_addr      = mem_addr;
   assign bus.o_rsp_valid     = rsp_valid;
   assign bus.o_rsp_data      = rsp_data;
   assign bus.o_rsp_err       = (state == RESP) && err_q;

endmodule

// File: tb/tb_misaligned_load_unit.sv
// Directed bench for the misaligned load unit with a scripted zero/multi-wait memory.
// Two instances: misaligned support on (main) and off (fault variant).
// Inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_misaligned_load_unit;

   logic clk;
   logic rst_n;

   int n_checks;
   int n_errors;

   misaligned_load_unit_if #(.XLEN(32)) bus ();
   misaligned_load_unit_if #(.XLEN(32)) bus_nm ();

   misaligned_load_unit #(.XLEN(32), .SUPPORT_MISALIGNED(1)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   misaligned_load_unit #(.XLEN(32), .SUPPORT_MISALIGNED(0)) dut_nm (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus_nm)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Results of the last scripted load
   logic [31:0] r_data;
   logic        r_err;
   int          r_nreads;
   int          r_lat;
   logic [31:0] r_addr0;
   logic [31:0] r_addr1;
   bit          r_stable;

   // Monitors
   bit overlap_seen;
   bit nm_mem_seen;
   bit rsp_watch;
   bit rsp_after_rst;

   initial begin
      overlap_seen  = 1'b0;
      nm_mem_seen   = 1'b0;
      rsp_after_rst = 1'b0;
   end

   always @(posedge clk) begin
      if (bus.o_rsp_valid && bus.o_mem_req_valid) overlap_seen <= 1'b1;
      if (bus_nm.o_mem_req_valid) nm_mem_seen <= 1'b1;
      if (rsp_watch && bus.o_rsp_valid) rsp_after_rst <= 1'b1;
   end

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_1000: return 32'h8877_6655;
         32'h0000_1004: return 32'h4433_22F1;
         32'hFFFF_FFFC: return 32'hAABB_CCDD;
         32'h0000_0000: return 32'h1122_3344;
         default:       return 32'hDEAD_BEEF;
      endcase
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One load on the main instance; each memory request stalls mem_stall cycles,
   // the response is held rsp_stall cycles before the consumer accepts.
   task automatic do_load(input logic [2:0] f3, input logic [31:0] a,
                          input int mem_stall, input int rsp_stall);
      int          cyc;
      int          stall_cnt;
      int          rsp_cnt;
      bit          will_acc;
      bit          in_req;
      bit          seen;
      bit          done;
      logic [31:0] acc_addr;
      logic [31:0] req_addr;
      r_nreads = 0; r_lat = -1; r_stable = 1'b1;
      r_data = '0; r_err = 1'b0; r_addr0 = '0; r_addr1 = '0;
      cyc = 0; stall_cnt = 0; rsp_cnt = 0;
      will_acc = 1'b0; in_req = 1'b0; seen = 1'b0; done = 1'b0;
      acc_addr = '0; req_addr = '0;
      @(negedge clk);
      check("req_ready_idle", {63'd0, bus.o_req_ready}, 64'd1);
      bus.i_req_valid = 1'b1;
      bus.i_addr      = a;
      bus.i_funct3    = f3;
      while (!done && cyc < 200) begin
         @(negedge clk);
         cyc++;
         bus.i_req_valid     = 1'b0;
         bus.i_mem_rsp_valid = will_acc;
         bus.i_mem_rdata     = will_acc ? mem_word(acc_addr) : 32'h0;
         will_acc            = 1'b0;
         bus.i_rsp_ready     = 1'b0;
         if (bus.o_rsp_valid) begin
            if (!seen) begin
               seen   = 1'b1;
               r_lat  = cyc;
               r_data = bus.o_rsp_data;
               r_err  = bus.o_rsp_err;
            end else if (bus.o_rsp_data !== r_data || bus.o_rsp_err !== r_err) begin
               r_stable = 1'b0;
            end
            if (rsp_cnt >= rsp_stall) begin
               bus.i_rsp_ready = 1'b1;
               done = 1'b1;
            end else begin
               rsp_cnt++;
            end
         end
         bus.i_mem_req_ready = 1'b0;
         if (bus.o_mem_req_valid) begin
            if (!in_req) begin
               in_req   = 1'b1;
               req_addr = bus.o_mem_addr;
            end else if (bus.o_mem_addr !== req_addr) begin
               r_stable = 1'b0;
            end
            if (stall_cnt < mem_stall) begin
               stall_cnt++;
            end else begin
               bus.i_mem_req_ready = 1'b1;
               will_acc = 1'b1;
               acc_addr = bus.o_mem_addr;
               if (r_nreads == 0) r_addr0 = bus.o_mem_addr;
               else               r_addr1 = bus.o_mem_addr;
               r_nreads++;
               in_req    = 1'b0;
               stall_cnt = 0;
            end
         end
      end
      @(negedge clk);
      bus.i_rsp_ready     = 1'b0;
      bus.i_mem_req_ready = 1'b0;
      bus.i_mem_rsp_valid = 1'b0;
      if (!done) check("load_timeout", 64'd0, 64'd1);
      check("back_to_idle", {63'd0, bus.o_req_ready}, 64'd1);
   endtask

   // Directed vector: funct3, address, expected data, err, read count, latency
   task automatic load_vec(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] exp_data, input logic exp_err,
                           input int exp_reads, input int exp_lat);
      do_load(f3, a, 0, 0);
      check({tag, "_data"},  {32'd0, r_data}, {32'd0, exp_data});
      check({tag, "_err"},   {63'd0, r_err}, {63'd0, exp_err});
      check({tag, "_reads"}, 64'(r_nreads), 64'(exp_reads));
      check({tag, "_lat"},   64'(r_lat), 64'(exp_lat));
   endtask

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      rsp_watch = 1'b0;
      rst_n     = 1'b0;
      bus.i_req_valid = 1'b0; bus.i_addr = '0; bus.i_funct3 = '0;
      bus.i_mem_req_ready = 1'b0; bus.i_mem_rsp_valid = 1'b0; bus.i_mem_rdata = '0;
      bus.i_rsp_ready = 1'b0;
      bus_nm.i_req_valid = 1'b0; bus_nm.i_addr = '0; bus_nm.i_funct3 = '0;
      bus_nm.i_mem_req_ready = 1'b1; bus_nm.i_mem_rsp_valid = 1'b0; bus_nm.i_mem_rdata = '0;
      bus_nm.i_rsp_ready = 1'b0;

      repeat (2) @(negedge clk);
      check("rst_req_ready", {63'd0, bus.o_req_ready}, 64'd1);
      check("rst_mem_valid", {63'd0, bus.o_mem_req_valid}, 64'd0);
      check("rst_mem_addr",  {32'd0, bus.o_mem_addr}, 64'd0);
      check("rst_rsp_valid", {63'd0, bus.o_rsp_valid}, 64'd0);
      check("rst_rsp_data",  {32'd0, bus.o_rsp_data}, 64'd0);
      check("rst_rsp_err",   {63'd0, bus.o_rsp_err}, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Aligned and crossing loads, zero-wait memory
      load_vec("lb_1001",  3'b000, 32'h0000_1001, 32'h0000_0066, 1'b0, 1, 3);
      check("lb_1001_addr", {32'd0, r_addr0}, 64'h1000);
      load_vec("lb_1003",  3'b000, 32'h0000_1003, 32'hFFFF_FF88, 1'b0, 1, 3);
      load_vec("lb_1000",  3'b000, 32'h0000_1000, 32'h0000_0055, 1'b0, 1, 3);
      load_vec("lh_1002",  3'b001, 32'h0000_1002, 32'hFFFF_8877, 1'b0, 1, 3);
      load_vec("lhu_1002", 3'b101, 32'h0000_1002, 32'h0000_8877, 1'b0, 1, 3);
      load_vec("lh_1003",  3'b001, 32'h0000_1003, 32'hFFFF_F188, 1'b0, 2, 5);
      check("lh_1003_addr0", {32'd0, r_addr0}, 64'h1000);
      check("lh_1003_addr1", {32'd0, r_addr1}, 64'h1004);
      load_vec("lhu_1003", 3'b101, 32'h0000_1003, 32'h0000_F188, 1'b0, 2, 5);
      load_vec("lw_1002",  3'b010, 32'h0000_1002, 32'h22F1_8877, 1'b0, 2, 5);
      load_vec("lw_1001",  3'b010, 32'h0000_1001, 32'hF188_7766, 1'b0, 2, 5);

      // Illegal funct3 at XLEN=32
      load_vec("f3_111", 3'b111, 32'h0000_1000, 32'h0, 1'b1, 0, 1);
      load_vec("f3_011", 3'b011, 32'h0000_1000, 32'h0, 1'b1, 0, 1);
      load_vec("f3_110", 3'b110, 32'h0000_1000, 32'h0, 1'b1, 0, 1);

      // Backpressure on both channels
      do_load(3'b010, 32'h0000_1000, 4, 3);
      check("bp_lw_data",   {32'd0, r_data}, 64'h8877_6655);
      check("bp_lw_stable", {63'd0, r_stable}, 64'd1);
      check("bp_lw_lat",    64'(r_lat), 64'd7);
      do_load(3'b001, 32'h0000_1003, 2, 2);
      check("bp_lh_data",   {32'd0, r_data}, 64'hFFFF_F188);
      check("bp_lh_stable", {63'd0, r_stable}, 64'd1);
      check("bp_lh_reads",  64'(r_nreads), 64'd2);

      // Address wrap on the second read
      load_vec("lw_wrap", 3'b010, 32'hFFFF_FFFE, 32'h3344_AABB, 1'b0, 2, 5);
      check("wrap_addr0", {32'd0, r_addr0}, 64'hFFFF_FFFC);
      check("wrap_addr1", {32'd0, r_addr1}, 64'h0);

      check("no_overlap", {63'd0, overlap_seen}, 64'd0);

      // Misaligned support disabled: crossing load faults without memory traffic
      @(negedge clk);
      check("nm_ready", {63'd0, bus_nm.o_req_ready}, 64'd1);
      bus_nm.i_req_valid = 1'b1; bus_nm.i_addr = 32'h0000_1002; bus_nm.i_funct3 = 3'b010;
      @(negedge clk);
      bus_nm.i_req_valid = 1'b0;
      check("nm_rsp_valid", {63'd0, bus_nm.o_rsp_valid}, 64'd1);
      check("nm_rsp_err",   {63'd0, bus_nm.o_rsp_err}, 64'd1);
      check("nm_rsp_data",  {32'd0, bus_nm.o_rsp_data}, 64'd0);
      bus_nm.i_rsp_ready = 1'b1;
      @(negedge clk);
      bus_nm.i_rsp_ready = 1'b0;
      check("nm_idle", {63'd0, bus_nm.o_req_ready}, 64'd1);
      check("nm_no_mem", {63'd0, nm_mem_seen}, 64'd0);
      // Non-crossing load still issues its read when support is disabled
      bus_nm.i_req_valid = 1'b1; bus_nm.i_addr = 32'h0000_1001; bus_nm.i_funct3 = 3'b000;
      @(negedge clk);
      bus_nm.i_req_valid = 1'b0;
      check("nm_lb_memreq", {63'd0, bus_nm.o_mem_req_valid}, 64'd1);
      check("nm_lb_addr",   {32'd0, bus_nm.o_mem_addr}, 64'h1000);

      // Reset while waiting for the second read
      @(negedge clk);
      bus.i_req_valid = 1'b1; bus.i_addr = 32'h0000_1003; bus.i_funct3 = 3'b001;
      bus.i_mem_req_ready = 1'b1;
      @(negedge clk);
      bus.i_req_valid = 1'b0;
      @(negedge clk);
      bus.i_mem_rsp_valid = 1'b1; bus.i_mem_rdata = mem_word(32'h0000_1000);
      @(negedge clk);
      bus.i_mem_rsp_valid = 1'b0;
      @(negedge clk);
      bus.i_mem_req_ready = 1'b0;
      check("w2_no_memreq", {63'd0, bus.o_mem_req_valid}, 64'd0);
      check("w2_no_rsp",    {63'd0, bus.o_rsp_valid}, 64'd0);
      rsp_watch = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check("w2_rst_ready", {63'd0, bus.o_req_ready}, 64'd1);
      check("w2_rst_rsp",   {63'd0, bus.o_rsp_valid}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      bus.i_mem_rsp_valid = 1'b1; bus.i_mem_rdata = 32'h1234_5678;
      @(negedge clk);
      bus.i_mem_rsp_valid = 1'b0;
      repeat (3) @(negedge clk);
      rsp_watch = 1'b0;
      check("w2_stray_ignored", {63'd0, rsp_after_rst}, 64'd0);
      check("w2_still_idle",    {63'd0, bus.o_req_ready}, 64'd1);
      load_vec("lbu_after_rst", 3'b100, 32'h0000_1000, 32'h0000_0055, 1'b0, 1, 3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule

// File: doc/misaligned_load_unit.md
MISALIGNED_LOAD_UNIT -- requirements
Module: misaligned_load_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the data/address width; legal values are 32 and 64.
REQ-002 The block SHALL have parameter SUPPORT_MISALIGNED, default 1; when 1, word-crossing loads use two memory reads, and when 0 they fault.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low; ports are i_clk (in, 1, clock) and i_rst_n (in, 1, async active-low reset).
REQ-004 Request ports SHALL be: i_req_valid in 1, request present; o_req_ready out 1, unit idle; i_addr in XLEN, byte address; i_funct3 in 3, load type.
REQ-005 Memory ports SHALL be: o_mem_req_valid out 1, read request; i_mem_req_ready in 1, memory accepts; o_mem_addr out XLEN, word-aligned address; i_mem_rsp_valid in 1, read data valid; i_mem_rdata in XLEN, read word.
REQ-006 Response ports SHALL be: o_rsp_valid out 1, result valid; i_rsp_ready in 1, consumer accepts; o_rsp_data out XLEN, extended load result; o_rsp_err out 1, illegal funct3 or misaligned fault.

Function
REQ-007 Supported funct3 SHALL be LB 000, LH 001, LW 010, LBU 100, LHU 101; LD 011 and LWU 110 are also supported when XLEN=64.
REQ-008 Any other funct3 value SHALL be illegal: no memory access, o_rsp_err=1, o_rsp_data=0.
REQ-009 Definitions: B = XLEN/8; off = i_addr mod B; size = 1/2/4/8 bytes; crossing = (off + size > B).
REQ-010 The FSM SHALL have states IDLE, REQ1, WAIT1, REQ2, WAIT2, RESP; o_req_ready=1 only in IDLE.
REQ-011 In IDLE, a handshake (i_req_valid & o_req_ready) SHALL latch addr and funct3, then move to RESP on error, otherwise to REQ1.
REQ-012 In REQ1, o_mem_req_valid=1 and o_mem_addr = addr with the low log2(B) bits cleared; on i_mem_req_ready the FSM SHALL move to WAIT1.
REQ-013 In WAIT1, on i_mem_rsp_valid the block SHALL capture lo = i_mem_rdata, then move to REQ2 if crossing, otherwise to RESP.
REQ-014 In REQ2, o_mem_addr SHALL equal aligned addr + B, wrapping modulo 2^XLEN; on i_mem_req_ready the FSM SHALL move to WAIT2.
REQ-015 In WAIT2, on i_mem_rsp_valid the block SHALL capture hi = i_mem_rdata and move to RESP.
REQ-016 Result SHALL be: bytes = ({hi,lo} >> 8*off)[8*size-1:0]; signed types sign-extend from bit 8*size-1, unsigned types zero-extend; when not crossing, hi is don't-care.
REQ-017 In RESP, o_rsp_valid SHALL hold with o_rsp_data/o_rsp_err stable until i_rsp_ready, then the FSM SHALL return to IDLE.
REQ-018 At most one memory transaction SHALL be outstanding; o_mem_req_valid SHALL hold with stable o_mem_addr until accepted.
REQ-019 i_mem_rsp_valid SHALL be ignored outside WAIT1/WAIT2; a response arriving in the same cycle as the request acceptance is not legal stimulus.
REQ-020 Zero-wait latency (memory ready=1, response in the cycle after acceptance) SHALL be: non-crossing, o_rsp_valid 3 cycles after the request handshake; crossing, 5 cycles; error, 1 cycle.
REQ-021 o_rsp_valid and o_mem_req_valid SHALL never be asserted in the same cycle.

Reset
REQ-022 On i_rst_n=0 (asynchronous), the FSM SHALL go to IDLE and the outputs SHALL reset to: o_req_ready=1, o_mem_req_valid=0, o_mem_addr=0, o_rsp_valid=0, o_rsp_data=0, o_rsp_err=0, with internal lo/hi cleared.
REQ-023 Reset in any state SHALL abandon the operation with no response; memory responses arriving after reset release SHALL be ignored per REQ-019.

Verification (XLEN=32; word@0x1000 = 0x88776655, word@0x1004 = 0x443322F1)
REQ-024 LB @0x1001 -> one memory read of 0x1000; o_rsp_data=0x00000066, err=0; LB @0x1003 -> 0xFFFFFF88.
REQ-025 LH @0x1003 -> reads 0x1000 then 0x1004; o_rsp_data=0xFFFFF188; LHU at the same address -> 0x0000F188; zero-wait latency is 5 cycles.
REQ-026 LW @0x1002 -> two reads; o_rsp_data=0x22F18877; with SUPPORT_MISALIGNED=0, same request -> no o_mem_req_valid, err=1, data=0, 1 cycle after handshake.
REQ-027 funct3=111 -> err=1, data=0, no memory request; funct3=011 at XLEN=32 -> err=1.
REQ-028 Backpressure: hold i_mem_req_ready=0 for 4 cycles and i_rsp_ready=0 for 3 cycles -> o_mem_addr and o_rsp_data stay stable; then LW @0x1000 -> 0x88776655; LW @0xFFFFFFFE -> second read at 0x00000000 (wrap).
REQ-029 Assert i_rst_n=0 in WAIT2 -> o_rsp_valid is never asserted and o_req_ready=1 immediately; a stray i_mem_rsp_valid after release is ignored; the next LBU @0x1000 -> 0x00000055.
